// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// HALT is only reachable when HALT_DETECT_EN is defined.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    ERR  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] HALT_WORD = 32'h00000000;
  localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous prefetch queue of fetch entries.
// Flush empties the queue and wins over a same-cycle push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t        mem [DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [PW:0]         count;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // the popped head and everything behind it is discarded together
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, fills the prefetch queue from the ROM,
// handles redirects and address faults. HALT_DETECT_EN adds zero-word halt.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          N        = 64,
  parameter int          DEPTH    = 2,
  parameter int          AW       = 6,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_pc,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_q,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst,
  output logic [N-1:0]  inst_pc,
  output logic          fetch_err
`ifdef HALT_DETECT_EN
  ,
  output logic          halted
`endif
);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [N-1:0]  fetch_pc;
  logic [N-1:0]  fetch_pc_nxt;
  logic          push;
  logic          pop;
  logic          flush;
  logic          set_err;
  logic          fault;
  logic          halt_hit;
  logic          full;
  logic          empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign imem_addr = fetch_pc[AW+1:2];
  assign fault     = (fetch_pc[1:0] != 2'b00) || (fetch_pc[N-1:AW+2] != '0);
  assign pop       = inst_valid && inst_ready;

`ifdef HALT_DETECT_EN
  assign halt_hit = (imem_q == HALT_WORD);
  assign halted   = (state == HALT);
`else
  assign halt_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      fetch_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (set_err) fetch_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    flush        = 1'b0;
    set_err      = 1'b0;
    if (redirect_valid) begin
      flush        = 1'b1;
      fetch_pc_nxt = redirect_pc;
      state_nxt    = RUN;
    end else begin
      case (state)
        RUN: begin
          if (fault) begin
            set_err   = 1'b1;
            state_nxt = ERR;
          end else if (halt_hit) begin
            // fetch_pc stays on the zero word so a later redirect is the only way out
            state_nxt = HALT;
          end else if (!full || pop) begin
            push         = 1'b1;
            fetch_pc_nxt = fetch_pc + N'(PC_STEP);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.inst = imem_q;
    push_entry.pc   = 64'(fetch_pc);
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign inst_valid = !empty;
  assign inst       = inst_valid ? head.inst : 32'h0;
  assign inst_pc    = inst_valid ? head.pc[N-1:0] : '0;

endmodule
